// File: rtl/hansen_mem_arbiter.sv
// rtl/hansen_mem_arbiter.sv - fetch/data arbiter onto one single-ported memory with starvation guard and watchdog
module hansen_mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 4,
   parameter int TIMEOUT    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int SC_W = $clog2(STARVE_MAX + 1);
   localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [SC_W-1:0] SC_MAX  = SC_W'(STARVE_MAX);
   localparam logic [WD_W-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_BUSY_I = 2'd1,
      S_BUSY_D = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic              w_i_win;
   logic              w_d_win;
   logic              w_timeout;
   logic [SC_W-1:0]   r_starve;
   logic [WD_W-1:0]   r_wdog;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_i_rvalid;
   logic [DATA_W-1:0] r_i_rdata;
   logic              r_i_err;
   logic              r_d_rvalid;
   logic [DATA_W-1:0] r_d_rdata;
   logic              r_d_err;

   // Watchdog fires on the last allowed BUSY cycle only if memory is still not ready.
   assign w_timeout = (TIMEOUT != 0) && (r_wdog == WD_LAST) && !mem_ready;

   assign mem_req   = (r_state != S_IDLE);
   assign mem_we    = r_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign i_rvalid  = r_i_rvalid;
   assign i_rdata   = r_i_rdata;
   assign i_err     = r_i_err;
   assign d_rvalid  = r_d_rvalid;
   assign d_rdata   = r_d_rdata;
   assign d_err     = r_d_err;

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Arbitration and next state: data wins unless fetch has been starved STARVE_MAX times.
   always_comb begin
      w_next  = r_state;
      w_i_win = 1'b0;
      w_d_win = 1'b0;
      i_gnt   = 1'b0;
      d_gnt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (d_req && !(i_req && (r_starve == SC_MAX))) begin
               w_d_win = 1'b1;
               w_next  = S_BUSY_D;
            end else if (i_req) begin
               w_i_win = 1'b1;
               w_next  = S_BUSY_I;
            end
            i_gnt = w_i_win;
            d_gnt = w_d_win;
         end
         S_BUSY_I, S_BUSY_D: begin
            if (mem_ready || w_timeout) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Starvation counter and watchdog bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_starve <= '0;
         r_wdog   <= '0;
      end else if (r_state == S_IDLE) begin
         r_wdog <= '0;
         if (w_i_win || !i_req) begin
            r_starve <= '0;
         end else if (w_d_win && (r_starve != SC_MAX)) begin
            r_starve <= r_starve + SC_W'(1);
         end
      end else if (TIMEOUT != 0) begin
         r_wdog <= r_wdog + WD_W'(1);
      end
   end

   // Latch the winning request so the memory sees stable signals for the whole access.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else if (w_d_win) begin
         r_we    <= d_we;
         r_addr  <= d_addr;
         r_wdata <= d_wdata;
      end else if (w_i_win) begin
         r_we    <= 1'b0;
         r_addr  <= i_addr;
         r_wdata <= '0;
      end
   end

   // Completion responses: one-cycle rvalid pulse, rdata/err held until the next completion.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_i_rvalid <= 1'b0;
         r_i_rdata  <= '0;
         r_i_err    <= 1'b0;
         r_d_rvalid <= 1'b0;
         r_d_rdata  <= '0;
         r_d_err    <= 1'b0;
      end else begin
         r_i_rvalid <= 1'b0;
         r_d_rvalid <= 1'b0;
         if (r_state == S_BUSY_I) begin
            if (mem_ready) begin
               r_i_rvalid <= 1'b1;
               r_i_rdata  <= mem_rdata;
               r_i_err    <= 1'b0;
            end else if (w_timeout) begin
               r_i_rvalid <= 1'b1;
               r_i_rdata  <= '0;
               r_i_err    <= 1'b1;
            end
         end
         if (r_state == S_BUSY_D) begin
            if (mem_ready) begin
               r_d_rvalid <= 1'b1;
               r_d_rdata  <= r_we ? '0 : mem_rdata;
               r_d_err    <= 1'b0;
            end else if (w_timeout) begin
               r_d_rvalid <= 1'b1;
               r_d_rdata  <= '0;
               r_d_err    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_hansen_mem_arbiter.sv
// tb/tb_hansen_mem_arbiter.sv - directed self-checking bench for hansen_mem_arbiter
module tb_hansen_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_req;
   logic [31:0] i_addr;
   logic        i_gnt;
   logic        i_rvalid;
   logic [31:0] i_rdata;
   logic        i_err;
   logic        d_req;
   logic        d_we;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [31:0] d_rdata;
   logic        d_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        mem_ok;

   int errors = 0;
   int checks = 0;

   hansen_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(16)
   ) dut (
      .clk(clk), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
      .i_rdata(i_rdata), .i_err(i_err),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   // Memory model: ready in the same cycle as mem_req when enabled; data derived from address.
   assign mem_ready = mem_req & mem_ok;
   assign mem_rdata = (mem_addr == 32'h10) ? 32'h00100093 : (mem_addr ^ 32'hCAFE0000);

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      reset = 1'b1; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
      d_addr = '0; d_wdata = '0; mem_ok = 1'b0;
      tick; tick;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req got %b exp 0", mem_req); end
      checks++; if ({i_rvalid, d_rvalid, i_err, d_err} !== 4'b0) begin errors++; $display("FAIL reset_rvalid_err got %b exp 0000", {i_rvalid, d_rvalid, i_err, d_err}); end
      checks++; if ({mem_we, mem_addr, mem_wdata} !== 65'b0) begin errors++; $display("FAIL reset_mem_bus got %b/%h/%h exp 0", mem_we, mem_addr, mem_wdata); end
      checks++; if ({i_rdata, d_rdata} !== 64'b0) begin errors++; $display("FAIL reset_rdata got %h/%h exp 0", i_rdata, d_rdata); end
      reset = 1'b0;
      tick;
   endtask

   task automatic test_single_fetch;
      i_req = 1'b1; i_addr = 32'h10; mem_ok = 1'b1;
      #1;
      checks++; if (i_gnt !== 1'b1 || d_gnt !== 1'b0) begin errors++; $display("FAIL fetch_gnt got i=%b d=%b exp i=1 d=0", i_gnt, d_gnt); end
      tick;
      i_req = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_mem got req=%b addr=%h we=%b exp 1/10/0", mem_req, mem_addr, mem_we); end
      checks++; if (i_gnt !== 1'b0 || i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_busy got gnt=%b rvalid=%b exp 0/0", i_gnt, i_rvalid); end
      tick;
      #1;
      checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00100093 || i_err !== 1'b0) begin errors++; $display("FAIL fetch_resp got v=%b d=%h e=%b exp 1/00100093/0", i_rvalid, i_rdata, i_err); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL fetch_done_req got %b exp 0", mem_req); end
      tick;
      #1;
      checks++; if (i_rvalid !== 1'b0) begin errors++; $display("FAIL fetch_pulse got %b exp 0", i_rvalid); end
   endtask

   task automatic test_data_write;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'hDEADBEEF; mem_ok = 1'b1;
      #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", d_gnt); end
      tick;
      d_req = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'hDEADBEEF)
         begin errors++; $display("FAIL wr_mem got req=%b we=%b addr=%h wd=%h exp 1/1/80/deadbeef", mem_req, mem_we, mem_addr, mem_wdata); end
      tick;
      #1;
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'h0 || d_err !== 1'b0) begin errors++; $display("FAIL wr_resp got v=%b d=%h e=%b exp 1/0/0", d_rvalid, d_rdata, d_err); end
      tick;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
      #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL rd_gnt got %b exp 1", d_gnt); end
      tick;
      d_req = 1'b0;
      tick;
      #1;
      checks++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hCAFE0040 || d_err !== 1'b0) begin errors++; $display("FAIL rd_resp got v=%b d=%h e=%b exp 1/cafe0040/0", d_rvalid, d_rdata, d_err); end
      tick;
   endtask

   task automatic test_starvation;
      int  n;
      logic exp_i;
      i_req = 1'b1; i_addr = 32'h100; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200; mem_ok = 1'b1;
      n = 0;
      for (int c = 0; c < 40 && n < 10; c++) begin
         #1;
         if (i_gnt || d_gnt) begin
            exp_i = ((n % 5) == 4);
            checks++;
            if (i_gnt !== exp_i || d_gnt !== !exp_i) begin
               errors++; $display("FAIL starve_order grant %0d got i=%b d=%b exp i=%b d=%b", n, i_gnt, d_gnt, exp_i, !exp_i);
            end
            n++;
         end
         tick;
      end
      checks++; if (n != 10) begin errors++; $display("FAIL starve_count got %0d grants exp 10", n); end
      i_req = 1'b0; d_req = 1'b0;
      tick; tick;
   endtask

   task automatic test_timeout;
      int n;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_ok = 1'b0;
      #1;
      checks++; if (d_gnt !== 1'b1) begin errors++; $display("FAIL to_gnt got %b exp 1", d_gnt); end
      tick;
      d_req = 1'b0;
      #1;
      n = 0;
      while (mem_req === 1'b1 && n < 40) begin
         if (d_rvalid !== 1'b0) begin checks++; errors++; $display("FAIL to_early_rvalid at %0d got 1 exp 0", n); end
         n++;
         tick;
         #1;
      end
      checks++; if (n != 16) begin errors++; $display("FAIL to_len got %0d cycles exp 16", n); end
      checks++; if (d_rvalid !== 1'b1 || d_err !== 1'b1 || d_rdata !== 32'h0) begin errors++; $display("FAIL to_resp got v=%b e=%b d=%h exp 1/1/0", d_rvalid, d_err, d_rdata); end
      i_req = 1'b1; i_addr = 32'h10; mem_ok = 1'b1;
      #1;
      checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL to_next_gnt got %b exp 1", i_gnt); end
      tick;
      i_req = 1'b0;
      tick;
      #1;
      checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00100093 || i_err !== 1'b0) begin errors++; $display("FAIL to_after got v=%b d=%h e=%b exp 1/00100093/0", i_rvalid, i_rdata, i_err); end
      tick;
   endtask

   task automatic test_reset_mid;
      i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h400; mem_ok = 1'b0;
      #1;
      checks++; if (d_gnt !== 1'b1 || i_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got d=%b i=%b exp 1/0", d_gnt, i_gnt); end
      tick;
      d_req = 1'b0; reset = 1'b1;
      #1;
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_busy got %b exp 1", mem_req); end
      tick;
      reset = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_drop got req=%b rvalid=%b exp 0/0", mem_req, d_rvalid); end
      checks++; if (i_gnt !== 1'b1) begin errors++; $display("FAIL rst_fetch_gnt got %b exp 1", i_gnt); end
      mem_ok = 1'b1;
      tick;
      i_req = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h10 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_fetch_mem got req=%b addr=%h dv=%b exp 1/10/0", mem_req, mem_addr, d_rvalid); end
      tick;
      #1;
      checks++; if (i_rvalid !== 1'b1 || i_rdata !== 32'h00100093 || d_rvalid !== 1'b0) begin errors++; $display("FAIL rst_fetch_resp got v=%b d=%h dv=%b exp 1/00100093/0", i_rvalid, i_rdata, d_rvalid); end
      tick;
   endtask

   task automatic test_back_to_back;
      logic [31:0] addrs [3];
      logic [31:0] exp_d [3];
      int g;
      int r;
      addrs[0] = 32'h0; addrs[1] = 32'h4; addrs[2] = 32'h8;
      exp_d[0] = 32'hCAFE0000; exp_d[1] = 32'hCAFE0004; exp_d[2] = 32'hCAFE0008;
      g = 0; r = 0; mem_ok = 1'b1;
      for (int c = 0; c < 12; c++) begin
         i_req  = (g < 3);
         i_addr = addrs[(g < 3) ? g : 2];
         #1;
         if (i_rvalid) begin
            checks++;
            if (r >= 3 || i_rdata !== exp_d[(r < 3) ? r : 2] || c != 2 * r + 2) begin
               errors++; $display("FAIL b2b_resp %0d got d=%h at cycle %0d exp %h at cycle %0d", r, i_rdata, c, exp_d[(r < 3) ? r : 2], 2 * r + 2);
            end
            r++;
         end
         if (i_gnt) g++;
         tick;
      end
      checks++; if (g != 3 || r != 3) begin errors++; $display("FAIL b2b_count got gnt=%0d rvalid=%0d exp 3/3", g, r); end
      i_req = 1'b0;
   endtask

   initial begin
      test_reset;
      test_single_fetch;
      test_data_write;
      test_starvation;
      test_timeout;
      test_reset_mid;
      test_back_to_back;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
